// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG sample BRAM capture path.
package ecg_pkg;

    localparam int ECG_SAMPLE_W = 16;
    localparam int ECG_ADDR_W   = 12;
    localparam int ECG_WORD_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FLUSH,
        ST_DONE
    } ecg_wr_state_t;

endpackage

// File: rtl/ecg_sample_packer.sv
// Pairs incoming ECG samples into one BRAM word (first sample in the low half)
// and zero-fills the high half when a trailing odd sample is flushed.
module ecg_sample_packer
    import ecg_pkg::*;
#(
    parameter int SAMPLE_W = ECG_SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic                  flush_i,
    input  logic [SAMPLE_W-1:0]   data_i,
    output logic                  half_o,
    output logic [2*SAMPLE_W-1:0] word_o
);

    logic [SAMPLE_W-1:0] lo_q, lo_d;
    logic [SAMPLE_W-1:0] hi_q, hi_d;
    logic                half_q, half_d;

    always_comb begin
        lo_d   = lo_q;
        hi_d   = hi_q;
        half_d = half_q;
        if (clear_i) begin
            half_d = 1'b0;
        end else if (flush_i) begin
            hi_d   = '0;
            half_d = 1'b0;
        end else if (accept_i) begin
            if (half_q) hi_d = data_i;
            else        lo_d = data_i;
            half_d = ~half_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            hi_q   <= '0;
            half_q <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            half_q <= half_d;
        end
    end

    assign half_o = half_q;
    assign word_o = {hi_q, lo_q};

endmodule

// File: rtl/ecg_bram_writer.sv
// Captures a valid/ready ECG sample stream into BRAM port A, two samples per word.
// Define ECG_WRITER_CIRC_EN for a circular buffer that only Stop terminates.
module ecg_bram_writer
    import ecg_pkg::*;
#(
    parameter int ADDR_W    = ECG_ADDR_W,
    parameter int SAMPLE_W  = ECG_SAMPLE_W,
    parameter int LAST_ADDR = (1 << ECG_ADDR_W) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [SAMPLE_W-1:0]   s_data_i,
    output logic [ADDR_W-1:0]     addra_o,
    output logic [2*SAMPLE_W-1:0] dina_o,
    output logic                  ena_o,
    output logic                  wea_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [ADDR_W:0]       word_count_o
);

`ifdef ECG_WRITER_CIRC_EN
    localparam bit CIRC = 1'b1;
`else
    localparam bit CIRC = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(LAST_ADDR + 1);

    ecg_wr_state_t     state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              wea_q, wea_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic accept, half, half_after, pair_done, final_pair, clear, flush;

    ecg_sample_packer #(.SAMPLE_W(SAMPLE_W)) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .accept_i (accept),
        .flush_i  (flush),
        .data_i   (s_data_i),
        .half_o   (half),
        .word_o   (dina_o)
    );

    assign accept     = s_valid_i && s_ready_q;
    assign pair_done  = accept && half;
    assign half_after = accept ? ~half : half;
    assign final_pair = pair_done && (addra_q == LAST_A);

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        s_ready_d    = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        clear        = 1'b0;
        flush        = 1'b0;
        addra_d      = addra_q;
        word_count_d = word_count_q;

        // Pointer and count advance once the registered write has been presented.
        if (wea_q) begin
            if (addra_q == LAST_A) addra_d = CIRC ? '0 : addra_q;
            else                   addra_d = addra_q + 1'b1;
            if (word_count_q != FULL_CNT) word_count_d = word_count_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d      = ST_FILL;
                    s_ready_d    = 1'b1;
                    busy_d       = 1'b1;
                    clear        = 1'b1;
                    addra_d      = '0;
                    word_count_d = '0;
                end
            end
            ST_FILL: begin
                s_ready_d = 1'b1;
                busy_d    = 1'b1;
                if (final_pair) begin
                    frame_done_d = 1'b1;
                    if (!CIRC) begin
                        state_d   = ST_DONE;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b0;
                    end
                end
                // A sample taken alongside Stop is already reflected in half_after.
                if (stop_i) begin
                    s_ready_d = 1'b0;
                    if (half_after) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d      = ST_DONE;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                flush        = 1'b1;
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wea_d = pair_done || flush;

    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s_ready_q    <= 1'b0;
            wea_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            addra_q      <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            wea_q        <= wea_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            addra_q      <= addra_d;
            word_count_q <= word_count_d;
        end
    end

    assign s_ready_o    = s_ready_q;
    assign addra_o      = addra_q;
    assign ena_o        = wea_q;
    assign wea_o        = wea_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign word_count_o = word_count_q;

endmodule

// File: tb/tb_ecg_bram_writer.sv
// Self-checking bench for ecg_bram_writer: logs every accepted sample and every
// port-A write, then compares the writes against words rebuilt from the sample log.
module tb_ecg_bram_writer;

    localparam int ADDR_W    = 12;
    localparam int SAMPLE_W  = 16;
    localparam int LAST_ADDR = 4095;
    localparam int DEPTH     = LAST_ADDR + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_i = 1'b0;
    logic                stop_i = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_data = '0;
    logic [ADDR_W-1:0]   addra;
    logic [31:0]         dina;
    logic                ena, wea, busy, frame_done;
    logic [ADDR_W:0]     word_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; int n_acc; } wr_t;
    typedef struct { logic wea; logic [ADDR_W-1:0] addr; } fd_t;

    logic [SAMPLE_W-1:0] acc_q[$];
    wr_t                 wr_q[$];
    fd_t                 fd_q[$];

    ecg_bram_writer #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .LAST_ADDR(LAST_ADDR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .addra_o      (addra),
        .dina_o       (dina),
        .ena_o        (ena),
        .wea_o        (wea),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .word_count_o (word_count)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge: a write is logged with the sample count seen before it.
    always @(negedge clk) begin
        if (wea) wr_q.push_back('{addra, dina, acc_q.size()});
        if (frame_done) fd_q.push_back('{wea, addra});
        if (s_valid && s_ready) acc_q.push_back(s_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        wr_q.delete();
        fd_q.delete();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    task automatic send(input logic [SAMPLE_W-1:0] d, input bit with_stop);
        bit got = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        stop_i  = with_stop;
        for (int w = 0; w < 100 && !got; w++) begin
            @(negedge clk);
            got = s_ready;
            tick();
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        stop_i  = 1'b0;
    endtask

    task automatic stream(input int n, input int duty, input bit incr, input bit stop_last);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99, 0)) >= duty) tick();
            send(incr ? SAMPLE_W'(i + 1) : SAMPLE_W'($urandom), stop_last && (i == n - 1));
        end
    endtask

    // Reference: word k = {sample 2k+1, sample 2k}, a lone trailing sample gets a zero
    // upper half, word k lands at k mod DEPTH and is written right after its last sample.
    task automatic verify(input string tag, input int exp_fd);
        int n  = acc_q.size();
        int nw = (n + 1) / 2;
        int nc = (wr_q.size() < nw) ? wr_q.size() : nw;
        check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(nw));
        for (int i = 0; i < nc; i++) begin
            logic [SAMPLE_W-1:0] lo = acc_q[2*i];
            logic [SAMPLE_W-1:0] hi = (2*i + 1 < n) ? acc_q[2*i+1] : '0;
            check({tag, "_addr"}, 64'(wr_q[i].addr), 64'(i % DEPTH));
            check({tag, "_data"}, 64'(wr_q[i].data), 64'({hi, lo}));
            check({tag, "_latency"}, 64'(wr_q[i].n_acc), 64'((2*i + 1 < n) ? 2*i + 2 : 2*i + 1));
        end
        check({tag, "_word_count"}, 64'(word_count), 64'((nw < DEPTH) ? nw : DEPTH));
        check({tag, "_frame_done_cnt"}, 64'(fd_q.size()), 64'(exp_fd));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_ready_after"}, 64'(s_ready), 64'd0);
    endtask

    initial begin
        #12;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_addra", 64'(addra), 64'd0);
        check("rst_dina", 64'(dina), 64'd0);
        check("rst_ena", 64'(ena), 64'd0);
        check("rst_wea", 64'(wea), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Incrementing samples, gapless, then an idle Stop with no half word pending.
        clear_logs();
        pulse_start();
        check("t1_ready_after_start", 64'(s_ready), 64'd1);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        stream(8, 100, 1'b1, 1'b0);
        repeat (3) tick();
        check("t1_word_count", 64'(word_count), 64'd4);
        pulse_stop();
        repeat (2) tick();
        verify("t1", 1);
        if (wr_q.size() == 4) begin
            check("t1_word0", 64'(wr_q[0].data), 64'h0002_0001);
            check("t1_word3", 64'(wr_q[3].data), 64'h0008_0007);
        end

        // Full frame.
        clear_logs();
        pulse_start();
`ifdef ECG_WRITER_CIRC_EN
        stream(2*DEPTH + 2, 100, 1'b0, 1'b0);
        repeat (3) tick();
        check("circ_ready_before_stop", 64'(s_ready), 64'd1);
        pulse_stop();
        repeat (3) tick();
        verify("circ", 2);
`else
        stream(2*DEPTH, 100, 1'b0, 1'b0);
        repeat (3) tick();
        check("full_ready_after", 64'(s_ready), 64'd0);
        s_valid = 1'b1;
        repeat (5) tick();
        s_valid = 1'b0;
        check("full_no_extra_sample", 64'(acc_q.size()), 64'(2*DEPTH));
        verify("full", 1);
`endif
        if (fd_q.size() > 0) begin
            check("full_fd_with_write", 64'(fd_q[0].wea), 64'd1);
            check("full_fd_addr", 64'(fd_q[0].addr), 64'(LAST_ADDR));
        end

        // Odd sample count, then Stop: the last sample is flushed alone.
        clear_logs();
        pulse_start();
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b0);
        tick();
        pulse_stop();
        repeat (3) tick();
        verify("flush", 1);
        if (wr_q.size() == 2) begin
            check("flush_word1", 64'(wr_q[1].data), 64'h0000_3333);
            check("flush_addr1", 64'(wr_q[1].addr), 64'd1);
        end
        if (fd_q.size() > 0) begin
            check("flush_fd_with_write", 64'(fd_q[0].wea), 64'd1);
            check("flush_fd_addr", 64'(fd_q[0].addr), 64'd1);
        end
        check("flush_word_count", 64'(word_count), 64'd2);

        // Random valid gaps.
        clear_logs();
        pulse_start();
        stream(100, 50, 1'b0, 1'b0);
        repeat (2) tick();
        pulse_stop();
        repeat (3) tick();
        verify("gaps", 1);

        // Stop in the same cycle as an accepted sample: odd then even total.
        clear_logs();
        pulse_start();
        stream(5, 100, 1'b0, 1'b1);
        repeat (4) tick();
        verify("stop_odd", 1);
        clear_logs();
        pulse_start();
        stream(6, 100, 1'b0, 1'b1);
        repeat (4) tick();
        verify("stop_even", 1);

        // Start during FILL is ignored.
        clear_logs();
        pulse_start();
        stream(4, 100, 1'b1, 1'b0);
        pulse_start();
        stream(2, 100, 1'b1, 1'b0);
        repeat (2) tick();
        check("restart_ignored_count", 64'(word_count), 64'd3);
        pulse_stop();
        repeat (2) tick();
        verify("start_in_fill", 1);

        // Reset in the middle of a frame while the fifth write is on the port.
        clear_logs();
        pulse_start();
        stream(10, 100, 1'b0, 1'b0);
        check("mid_wea_before_reset", 64'(wea), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_wea_async", 64'(wea), 64'd0);
        check("mid_ena_async", 64'(ena), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_word_count", 64'(word_count), 64'd0);
        check("mid_writes_logged", 64'(wr_q.size()), 64'd4);
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        pulse_start();
        stream(4, 100, 1'b0, 1'b0);
        tick();
        pulse_stop();
        repeat (2) tick();
        verify("after_reset", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
